nabp_angle_scheduler: RTL and testbench

Sequences the projection angles of one back-projection pass and feeds per-angle accumulator bases to the swap controller. On a kick it walks angle indices from 0 to `ANGLE_LEN-1` and fetches each angle's shift and map bases from an external synchronous LUT. Each angle is presented through the `hs_has_next_angle` / `hs_next_angle_ack` handshake. It sits between the top-level kick logic and the swap controller, and owns the angle counter for the whole pass.

---
 rtl/nabp_angle_scheduler.sv | 189 ++++++++++++++++++
 tb/tb_nabp_angle_scheduler.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nabp_angle_scheduler.sv
// nabp_angle_scheduler
// Walks the projection angles of one back-projection pass, fetches each
// angle's accumulator bases from an external synchronous LUT and presents
// them to the swap controller through the has_next/ack handshake.
//
// Optional feature macro: NABP_ANGLE_STRIDE_EN
//   defined   -> angle_stride port exists; latched on the accepted kick
//                (a latched value of 0 behaves as 1)
//   undefined -> stride is the constant 1; every angle of the pass is shown
module nabp_angle_scheduler #(
  parameter int ANGLE_LEN = 180,
  parameter int ANGLE_W   = 8,
  parameter int DATA_W    = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  kick,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  lut_en,
  output logic [ANGLE_W-1:0]    lut_addr,
  input  logic [3*DATA_W-1:0]   lut_data,
  output logic [ANGLE_W-1:0]    angle,
  output logic [DATA_W-1:0]     sh_accu_base,
  output logic [DATA_W-1:0]     mp_accu_init,
  output logic [DATA_W-1:0]     mp_accu_base,
  output logic                  angle_valid,
  output logic                  hs_has_next_angle,
  input  logic                  hs_next_angle_ack
`ifdef NABP_ANGLE_STRIDE_EN
  ,
  input  logic [ANGLE_W-1:0]    angle_stride
`endif
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_CAPTURE = 3'd2,
    S_PRESENT = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  // Pass length widened by one bit so angle+stride never wraps before the
  // end-of-pass compare.
  localparam logic [ANGLE_W:0] LP_LEN = (ANGLE_W+1)'(ANGLE_LEN);

  state_t               r_state;
  state_t               w_next;

  logic [ANGLE_W-1:0]   r_angle;
  logic [DATA_W-1:0]    r_sh_base;
  logic [DATA_W-1:0]    r_mp_init;
  logic [DATA_W-1:0]    r_mp_base;

  logic [ANGLE_W-1:0]   w_stride;
  logic [ANGLE_W:0]     w_sum;
  logic                 w_last;

  logic                 w_busy;
  logic                 w_done;
  logic                 w_lut_en;
  logic                 w_valid;
  logic                 w_advance;
  logic                 w_capture;

`ifdef NABP_ANGLE_STRIDE_EN
  logic [ANGLE_W-1:0]   r_stride;

  // Latch the stride when a kick is accepted; zero behaves as a unit step.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_stride <= ANGLE_W'(1);
    end else if (r_state == S_IDLE && kick) begin
      r_stride <= (angle_stride == '0) ? ANGLE_W'(1) : angle_stride;
    end
  end

  assign w_stride = r_stride;
`else
  assign w_stride = ANGLE_W'(1);
`endif

  // End-of-pass detection depends only on registered values, so the
  // handshake outputs carry no combinational path from any input.
  assign w_sum  = {1'b0, r_angle} + {1'b0, w_stride};
  assign w_last = (w_sum >= LP_LEN);

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and state-decoded controls; abort overrides any non-idle move.
  always_comb begin
    w_next    = r_state;
    w_busy    = 1'b1;
    w_done    = 1'b0;
    w_lut_en  = 1'b0;
    w_valid   = 1'b0;
    w_advance = 1'b0;
    w_capture = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (kick) begin
          w_next = S_FETCH;
        end
      end
      S_FETCH: begin
        w_lut_en = 1'b1;
        w_next   = S_CAPTURE;
      end
      S_CAPTURE: begin
        w_capture = 1'b1;
        w_next    = S_PRESENT;
      end
      S_PRESENT: begin
        w_valid = 1'b1;
        if (hs_next_angle_ack) begin
          if (w_last) begin
            w_next = S_DONE;
          end else begin
            w_advance = 1'b1;
            w_next    = S_FETCH;
          end
        end
      end
      S_DONE: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        w_busy = 1'b0;
        w_next = S_IDLE;
`ifndef SYNTHESIS
        if (reset_n) begin
          $error("nabp_angle_scheduler: invalid state %0d", r_state);
        end
`endif
      end
    endcase
    if (abort && (r_state != S_IDLE)) begin
      w_next    = S_IDLE;
      w_advance = 1'b0;
    end
  end

  // Angle counter: parked at 0 while idle, stepped on a non-final ack.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_angle <= '0;
    end else if (r_state == S_IDLE) begin
      r_angle <= '0;
    end else if (w_advance) begin
      r_angle <= w_sum[ANGLE_W-1:0];
    end
  end

  // Capture the LUT word one cycle after the read strobe; abort leaves it.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sh_base <= '0;
      r_mp_init <= '0;
      r_mp_base <= '0;
    end else if (w_capture) begin
      r_sh_base <= lut_data[3*DATA_W-1:2*DATA_W];
      r_mp_init <= lut_data[2*DATA_W-1:DATA_W];
      r_mp_base <= lut_data[DATA_W-1:0];
    end
  end

  assign busy              = w_busy;
  assign done              = w_done;
  assign lut_en            = w_lut_en;
  assign lut_addr          = r_angle;
  assign angle             = r_angle;
  assign sh_accu_base      = r_sh_base;
  assign mp_accu_init      = r_mp_init;
  assign mp_accu_base      = r_mp_base;
  assign angle_valid       = w_valid;
  assign hs_has_next_angle = w_valid & ~w_last;

endmodule

// File: tb/tb_nabp_angle_scheduler.sv
// Directed bench for nabp_angle_scheduler: a 4-angle instance for the main
// handshake, hold, abort and reset cases, a 1-angle instance for the
// single-angle pass, and (with NABP_ANGLE_STRIDE_EN) a 10-angle stride instance.
module tb_nabp_angle_scheduler;
  localparam int AW = 8;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // LUT word for an angle: {angle, angle+0x100, angle+0x200}
  function automatic logic [3*DW-1:0] lut_word(input logic [AW-1:0] a);
    logic [DW-1:0] base;
    base = {8'h00, a};
    return {base, base + 16'h0100, base + 16'h0200};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- instance A: ANGLE_LEN = 4 ----------------
  logic a_kick = 1'b0, a_abort = 1'b0, a_ack = 1'b0;
  logic a_busy, a_done, a_lut_en, a_valid, a_has_next;
  logic [AW-1:0] a_lut_addr, a_angle;
  logic [3*DW-1:0] a_lut_data = '0;
  logic [DW-1:0] a_sh, a_mi, a_mb;

  nabp_angle_scheduler #(.ANGLE_LEN(4), .ANGLE_W(AW), .DATA_W(DW)) u_a (
    .clk(clk), .reset_n(reset_n), .kick(a_kick), .abort(a_abort),
    .busy(a_busy), .done(a_done), .lut_en(a_lut_en), .lut_addr(a_lut_addr),
    .lut_data(a_lut_data), .angle(a_angle), .sh_accu_base(a_sh),
    .mp_accu_init(a_mi), .mp_accu_base(a_mb), .angle_valid(a_valid),
    .hs_has_next_angle(a_has_next), .hs_next_angle_ack(a_ack)
`ifdef NABP_ANGLE_STRIDE_EN
    , .angle_stride(8'd1)
`endif
  );

  always @(posedge clk) if (a_lut_en) a_lut_data <= lut_word(a_lut_addr);

  // ---------------- instance B: ANGLE_LEN = 1 ----------------
  logic b_kick = 1'b0, b_abort = 1'b0, b_ack = 1'b0;
  logic b_busy, b_done, b_lut_en, b_valid, b_has_next;
  logic [AW-1:0] b_lut_addr, b_angle;
  logic [3*DW-1:0] b_lut_data = '0;
  logic [DW-1:0] b_sh, b_mi, b_mb;

  nabp_angle_scheduler #(.ANGLE_LEN(1), .ANGLE_W(AW), .DATA_W(DW)) u_b (
    .clk(clk), .reset_n(reset_n), .kick(b_kick), .abort(b_abort),
    .busy(b_busy), .done(b_done), .lut_en(b_lut_en), .lut_addr(b_lut_addr),
    .lut_data(b_lut_data), .angle(b_angle), .sh_accu_base(b_sh),
    .mp_accu_init(b_mi), .mp_accu_base(b_mb), .angle_valid(b_valid),
    .hs_has_next_angle(b_has_next), .hs_next_angle_ack(b_ack)
`ifdef NABP_ANGLE_STRIDE_EN
    , .angle_stride(8'd1)
`endif
  );

  always @(posedge clk) if (b_lut_en) b_lut_data <= lut_word(b_lut_addr);

`ifdef NABP_ANGLE_STRIDE_EN
  // ---------------- instance C: ANGLE_LEN = 10, strided ----------------
  logic c_kick = 1'b0, c_abort = 1'b0, c_ack = 1'b0;
  logic [AW-1:0] c_stride = '0;
  logic c_busy, c_done, c_lut_en, c_valid, c_has_next;
  logic [AW-1:0] c_lut_addr, c_angle;
  logic [3*DW-1:0] c_lut_data = '0;
  logic [DW-1:0] c_sh, c_mi, c_mb;

  nabp_angle_scheduler #(.ANGLE_LEN(10), .ANGLE_W(AW), .DATA_W(DW)) u_c (
    .clk(clk), .reset_n(reset_n), .kick(c_kick), .abort(c_abort),
    .busy(c_busy), .done(c_done), .lut_en(c_lut_en), .lut_addr(c_lut_addr),
    .lut_data(c_lut_data), .angle(c_angle), .sh_accu_base(c_sh),
    .mp_accu_init(c_mi), .mp_accu_base(c_mb), .angle_valid(c_valid),
    .hs_has_next_angle(c_has_next), .hs_next_angle_ack(c_ack),
    .angle_stride(c_stride)
  );

  always @(posedge clk) if (c_lut_en) c_lut_data <= lut_word(c_lut_addr);

  // One strided pass: n_exp angles spaced by step, acked immediately.
  task automatic run_c(input logic [AW-1:0] stride, input int n_exp, input int step);
    c_stride = stride;
    c_kick = 1'b1;
    tick();
    c_kick = 1'b0;
    c_stride = 8'd5;            // must be ignored: stride is latched at kick
    tick();
    tick();
    for (int i = 0; i < n_exp; i++) begin
      check($sformatf("c_valid[s%0d,%0d]", stride, i), c_valid, 1'b1);
      check($sformatf("c_angle[s%0d,%0d]", stride, i), c_angle, i * step);
      check($sformatf("c_has_next[s%0d,%0d]", stride, i), c_has_next, (i != n_exp - 1));
      check($sformatf("c_sh[s%0d,%0d]", stride, i), c_sh, i * step);
      c_ack = 1'b1;
      tick();
      c_ack = 1'b0;
      if (i == n_exp - 1) begin
        check($sformatf("c_done[s%0d]", stride), c_done, 1'b1);
        tick();
        check($sformatf("c_busy_end[s%0d]", stride), c_busy, 1'b0);
      end else begin
        tick();
        tick();
      end
    end
  endtask
`endif

  // All observable outputs of instance A at their reset values.
  task automatic check_a_zero(input string tag);
    check({tag, "_busy"}, a_busy, 1'b0);
    check({tag, "_done"}, a_done, 1'b0);
    check({tag, "_lut_en"}, a_lut_en, 1'b0);
    check({tag, "_lut_addr"}, a_lut_addr, 8'd0);
    check({tag, "_angle"}, a_angle, 8'd0);
    check({tag, "_sh"}, a_sh, 16'd0);
    check({tag, "_mi"}, a_mi, 16'd0);
    check({tag, "_mb"}, a_mb, 16'd0);
    check({tag, "_valid"}, a_valid, 1'b0);
    check({tag, "_has_next"}, a_has_next, 1'b0);
  endtask

  initial begin
    // ---- reset ----
    reset_n = 1'b0;
    tick();
    tick();
    check_a_zero("rst");
    reset_n = 1'b1;
    tick();

    // ---- full pass of 4 angles, immediate ack ----
    a_kick = 1'b1;
    tick();                                   // cycle 1: FETCH
    a_kick = 1'b0;
    check("p1_lut_en_c1", a_lut_en, 1'b1);
    check("p1_lut_addr_c1", a_lut_addr, 8'd0);
    check("p1_busy_c1", a_busy, 1'b1);
    check("p1_valid_c1", a_valid, 1'b0);
    tick();                                   // cycle 2: CAPTURE
    check("p1_valid_c2", a_valid, 1'b0);
    check("p1_lut_en_c2", a_lut_en, 1'b0);
    tick();                                   // cycle 3: PRESENT
    for (int i = 0; i < 4; i++) begin
      check($sformatf("p1_valid[%0d]", i), a_valid, 1'b1);
      check($sformatf("p1_angle[%0d]", i), a_angle, i);
      check($sformatf("p1_has_next[%0d]", i), a_has_next, (i < 3));
      check($sformatf("p1_sh[%0d]", i), a_sh, i);
      check($sformatf("p1_mi[%0d]", i), a_mi, 16'h0100 + i);
      check($sformatf("p1_mb[%0d]", i), a_mb, 16'h0200 + i);
      a_ack = 1'b1;
      tick();                                 // k+1
      a_ack = 1'b0;
      if (i < 3) begin
        check($sformatf("p1_valid_k1[%0d]", i), a_valid, 1'b0);
        check($sformatf("p1_done_k1[%0d]", i), a_done, 1'b0);
        check($sformatf("p1_lut_addr[%0d]", i), a_lut_addr, i + 1);
        tick();                               // k+2
        check($sformatf("p1_valid_k2[%0d]", i), a_valid, 1'b0);
        tick();                               // k+3
      end else begin
        check("p1_done_pulse", a_done, 1'b1);
        check("p1_busy_done", a_busy, 1'b1);
        check("p1_valid_done", a_valid, 1'b0);
      end
    end
    tick();                                   // k+2: idle again
    check("p1_done_end", a_done, 1'b0);
    check("p1_busy_end", a_busy, 1'b0);

    // ---- new kick accepted at k+2; hold ack low 10 cycles with kick high ----
    a_kick = 1'b1;
    tick();
    a_kick = 1'b0;
    check("p2_lut_en", a_lut_en, 1'b1);
    tick();
    tick();
    check("p2_valid", a_valid, 1'b1);
    a_kick = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("hold_valid[%0d]", i), a_valid, 1'b1);
      check($sformatf("hold_angle[%0d]", i), a_angle, 8'd0);
      check($sformatf("hold_sh[%0d]", i), a_sh, 16'h0000);
      check($sformatf("hold_mb[%0d]", i), a_mb, 16'h0200);
      check($sformatf("hold_lut_en[%0d]", i), a_lut_en, 1'b0);
    end
    a_kick = 1'b0;

    // ---- abort during CAPTURE of angle 1 ----
    a_ack = 1'b1;
    tick();                                   // FETCH angle 1
    a_ack = 1'b0;
    check("ab_lut_addr", a_lut_addr, 8'd1);
    tick();                                   // CAPTURE angle 1
    a_abort = 1'b1;
    tick();
    a_abort = 1'b0;
    check("ab_busy", a_busy, 1'b0);
    check("ab_valid", a_valid, 1'b0);
    check("ab_done", a_done, 1'b0);
    tick();
    check("ab_done2", a_done, 1'b0);
    check("ab_angle_idle", a_angle, 8'd0);
    // kick together with abort in IDLE: kick wins
    a_kick = 1'b1;
    a_abort = 1'b1;
    tick();
    a_kick = 1'b0;
    a_abort = 1'b0;
    check("ka_busy", a_busy, 1'b1);
    check("ka_lut_en", a_lut_en, 1'b1);
    check("ka_lut_addr", a_lut_addr, 8'd0);
    tick();
    tick();
    check("ka_valid", a_valid, 1'b1);
    check("ka_angle", a_angle, 8'd0);
    check("ka_sh", a_sh, 16'h0000);

    // ---- advance to angle 2, then reset mid-pass ----
    for (int i = 0; i < 2; i++) begin
      a_ack = 1'b1;
      tick();
      a_ack = 1'b0;
      tick();
      tick();
    end
    check("mr_valid", a_valid, 1'b1);
    check("mr_angle", a_angle, 8'd2);
    check("mr_sh", a_sh, 16'h0002);
    reset_n = 1'b0;
    tick();
    check_a_zero("mr");
    reset_n = 1'b1;
    a_kick = 1'b1;
    tick();
    a_kick = 1'b0;
    tick();
    tick();
    check("mr_restart_valid", a_valid, 1'b1);
    check("mr_restart_angle", a_angle, 8'd0);
    check("mr_restart_mi", a_mi, 16'h0100);

    // ---- single-angle pass ----
    b_kick = 1'b1;
    tick();
    b_kick = 1'b0;
    check("one_lut_en", b_lut_en, 1'b1);
    tick();
    tick();
    check("one_valid", b_valid, 1'b1);
    check("one_angle", b_angle, 8'd0);
    check("one_has_next", b_has_next, 1'b0);
    check("one_mb", b_mb, 16'h0200);
    b_ack = 1'b1;
    tick();
    b_ack = 1'b0;
    check("one_done", b_done, 1'b1);
    check("one_valid_done", b_valid, 1'b0);
    tick();
    check("one_done_end", b_done, 1'b0);
    check("one_busy_end", b_busy, 1'b0);

`ifdef NABP_ANGLE_STRIDE_EN
    // ---- strided passes ----
    run_c(8'd3, 4, 3);
    tick();
    run_c(8'd0, 10, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
